// File: rtl/bp_be_scoreboard_mi.sv
// Multi-issue register scoreboard: per-register fixed-latency countdown or variable-latency
// mark, with RAW/WAW hazard reporting against in-flight state and older lanes of the bundle.
module bp_be_scoreboard_mi #(
    parameter  int num_issue_p      = 2,
    parameter  int num_rs_p         = 3,
    parameter  int num_clear_p      = 2,
    parameter  int reg_addr_width_p = 5,
    parameter  int lat_width_p      = 3,
    localparam int rf_els_lp        = 2 ** reg_addr_width_p
) (
    input  logic                                                      clk_i,
    input  logic                                                      reset_n_i,
    input  logic [num_issue_p-1:0]                                    score_v_i,
    input  logic [num_issue_p-1:0][reg_addr_width_p-1:0]              score_rd_i,
    input  logic [num_issue_p-1:0][lat_width_p-1:0]                   score_lat_i,
    input  logic [num_clear_p-1:0]                                    clear_v_i,
    input  logic [num_clear_p-1:0][reg_addr_width_p-1:0]              clear_rd_i,
    input  logic                                                      flush_i,
    input  logic [num_issue_p-1:0][num_rs_p-1:0][reg_addr_width_p-1:0] rs_i,
    input  logic [num_issue_p-1:0][reg_addr_width_p-1:0]              rd_i,
    output logic [num_issue_p-1:0][num_rs_p-1:0]                      rs_match_o,
    output logic [num_issue_p-1:0]                                    rd_match_o,
    output logic [rf_els_lp-1:0]                                      busy_o
);

    typedef logic [reg_addr_width_p-1:0] reg_addr_t;
    typedef logic [lat_width_p-1:0]      lat_t;

    logic [rf_els_lp-1:0] busy_q, busy_n;
    logic [rf_els_lp-1:0] var_q, var_n;
    lat_t                 cnt_q [rf_els_lp];
    lat_t                 cnt_n [rf_els_lp];

    // Later assignments override earlier ones, so the code order below is the priority
    // order reversed: countdown, then clear, then score, then flush.
    always_comb begin
        for (int r = 0; r < rf_els_lp; r++) begin
            // NOTE: every always_comb output gets a default first so no path holds a value (latch).
            busy_n[r] = busy_q[r];
            var_n[r]  = var_q[r];
            cnt_n[r]  = cnt_q[r];

            if (busy_q[r] && !var_q[r]) begin
                if (cnt_q[r] > lat_t'(1)) begin
                    cnt_n[r] = cnt_q[r] - lat_t'(1);
                end else begin
                    busy_n[r] = 1'b0;
                    cnt_n[r]  = '0;
                end
            end

            for (int c = 0; c < num_clear_p; c++) begin
                if (clear_v_i[c] && clear_rd_i[c] == reg_addr_t'(r)) begin
                    busy_n[r] = 1'b0;
                    var_n[r]  = 1'b0;
                    cnt_n[r]  = '0;
                end
            end

            // Ascending lane order lets the youngest lane win a same-rd collision.
            for (int l = 0; l < num_issue_p; l++) begin
                if (score_v_i[l] && score_rd_i[l] == reg_addr_t'(r)) begin
                    busy_n[r] = 1'b1;
                    var_n[r]  = (score_lat_i[l] == '0);
                    cnt_n[r]  = score_lat_i[l];
                end
            end

            if (flush_i || r == 0) begin
                busy_n[r] = 1'b0;
                var_n[r]  = 1'b0;
                cnt_n[r]  = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            busy_q <= '0;
            var_q  <= '0;
            // NOTE: the counter array is reset as well so every entry is fully zero under reset.
            for (int r = 0; r < rf_els_lp; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep all state updates on this edge simultaneous.
            busy_q <= busy_n;
            var_q  <= var_n;
            for (int r = 0; r < rf_els_lp; r++) begin
                cnt_q[r] <= cnt_n[r];
            end
        end
    end

    // Hazard on addr for a given lane: in-flight, or scored by an older lane this cycle.
    function automatic logic hazard(input reg_addr_t addr, input int lane,
                                    input logic [rf_els_lp-1:0] busy,
                                    input logic [num_issue_p-1:0] sv,
                                    input logic [num_issue_p-1:0][reg_addr_width_p-1:0] srd);
        logic hit;
        hit = busy[addr];
        for (int j = 0; j < lane; j++) begin
            if (sv[j] && srd[j] == addr) begin
                hit = 1'b1;
            end
        end
        return hit && (addr != '0);
    endfunction

    always_comb begin
        rs_match_o = '0;
        rd_match_o = '0;
        for (int i = 0; i < num_issue_p; i++) begin
            for (int k = 0; k < num_rs_p; k++) begin
                rs_match_o[i][k] = hazard(rs_i[i][k], i, busy_q, score_v_i, score_rd_i);
            end
            rd_match_o[i] = hazard(rd_i[i], i, busy_q, score_v_i, score_rd_i);
        end
    end

    assign busy_o = busy_q;

endmodule

// File: tb/tb_bp_be_scoreboard_mi.sv
// Bench for bp_be_scoreboard_mi: an absolute-cycle "busy until" model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_bp_be_scoreboard_mi;

    localparam int NI = 2;
    localparam int NR = 3;
    localparam int NC = 2;
    localparam int AW = 5;
    localparam int LW = 3;
    localparam int RF = 32;
    localparam longint INF = 64'sh3fff_ffff_ffff_ffff;

    logic                         clk = 1'b0;
    logic                         rst_n;
    logic [NI-1:0]                score_v;
    logic [NI-1:0][AW-1:0]        score_rd;
    logic [NI-1:0][LW-1:0]        score_lat;
    logic [NC-1:0]                clear_v;
    logic [NC-1:0][AW-1:0]        clear_rd;
    logic                         flush;
    logic [NI-1:0][NR-1:0][AW-1:0] rs;
    logic [NI-1:0][AW-1:0]        rd;
    logic [NI-1:0][NR-1:0]        rs_match;
    logic [NI-1:0]                rd_match;
    logic [RF-1:0]                busy;

    int checks   = 0;
    int failures = 0;

    bp_be_scoreboard_mi #(
        .num_issue_p(NI), .num_rs_p(NR), .num_clear_p(NC),
        .reg_addr_width_p(AW), .lat_width_p(LW)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .score_v_i(score_v), .score_rd_i(score_rd), .score_lat_i(score_lat),
        .clear_v_i(clear_v), .clear_rd_i(clear_rd), .flush_i(flush),
        .rs_i(rs), .rd_i(rd),
        .rs_match_o(rs_match), .rd_match_o(rd_match), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: register r is visible in cycle c iff busy_until[r] >= c.
    longint busy_until [RF] = '{default: -1};
    longint cyc = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < RF; r++) busy_until[r] <= -1;
        end else begin
            for (int c = 0; c < NC; c++)
                if (clear_v[c] && clear_rd[c] != 0) busy_until[clear_rd[c]] <= cyc;
            for (int l = 0; l < NI; l++)
                if (score_v[l] && score_rd[l] != 0)
                    busy_until[score_rd[l]] <= (score_lat[l] == 0) ? INF : cyc + longint'(score_lat[l]);
            if (flush)
                for (int r = 0; r < RF; r++) busy_until[r] <= cyc;
            cyc <= cyc + 1;
        end
    end

    logic [RF-1:0]         exp_busy;
    logic [NI-1:0][NR-1:0] exp_rs;
    logic [NI-1:0]         exp_rd;

    function automatic logic older_scores(input int lane, input logic [AW-1:0] a);
        logic h = 1'b0;
        for (int j = 0; j < lane; j++)
            if (score_v[j] && score_rd[j] == a) h = 1'b1;
        return h;
    endfunction

    always @(negedge clk) begin
        for (int r = 0; r < RF; r++) exp_busy[r] = (r != 0) && (busy_until[r] >= cyc);
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < NR; k++)
                exp_rs[i][k] = (rs[i][k] != 0) && (exp_busy[rs[i][k]] || older_scores(i, rs[i][k]));
            exp_rd[i] = (rd[i] != 0) && (exp_busy[rd[i]] || older_scores(i, rd[i]));
        end
        check("model_busy", 64'(busy), 64'(exp_busy));
        check("model_rs_match", 64'(rs_match), 64'(exp_rs));
        check("model_rd_match", 64'(rd_match), 64'(exp_rd));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        score_v = '0; score_rd = '0; score_lat = '0;
        clear_v = '0; clear_rd = '0; flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        rs = '0;
        rd = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'h0);
        rst_n = 1'b1;

        // Fixed latency: r5, L=3 -> visible cycles 1..3, clear at 4.
        rs[0][0] = 5'd5;
        score_v[0] = 1'b1; score_rd[0] = 5'd5; score_lat[0] = 3'd3;
        #1 check("fix_c0_rs", 64'(rs_match[0][0]), 64'd0);
        tick(); idle();
        for (int c = 1; c <= 3; c++) begin
            #1;
            check("fix_busy5", 64'(busy[5]), 64'd1);
            check("fix_rs5", 64'(rs_match[0][0]), 64'd1);
            tick();
        end
        #1;
        check("fix_c4_busy5", 64'(busy[5]), 64'd0);
        check("fix_c4_rs5", 64'(rs_match[0][0]), 64'd0);
        rs = '0;

        // Variable latency: r7 held until cleared.
        score_v[1] = 1'b1; score_rd[1] = 5'd7; score_lat[1] = 3'd0;
        tick(); idle();
        repeat (19) tick();
        check("var_c20_busy7", 64'(busy[7]), 64'd1);
        clear_v[1] = 1'b1; clear_rd[1] = 5'd7;
        #1 check("var_no_bypass", 64'(busy[7]), 64'd1);
        tick(); idle();
        check("var_cleared7", 64'(busy[7]), 64'd0);

        // Intra-bundle RAW/WAW against an older lane.
        score_v[0] = 1'b1; score_rd[0] = 5'd3; score_lat[0] = 3'd1;
        rs[1][0] = 5'd3; rd[1] = 5'd3; rd[0] = 5'd3; rs[0][1] = 5'd3;
        #1;
        check("intra_rs10", 64'(rs_match[1][0]), 64'd1);
        check("intra_rd1", 64'(rd_match[1]), 64'd1);
        check("intra_rs01", 64'(rs_match[0][1]), 64'd0);
        check("intra_rd0", 64'(rd_match[0]), 64'd0);
        tick(); idle();
        rs = '0; rd = '0;
        tick();

        // Score beats clear on the same entry.
        clear_v[0] = 1'b1; clear_rd[0] = 5'd9;
        score_v[0] = 1'b1; score_rd[0] = 5'd9; score_lat[0] = 3'd2;
        tick(); idle();
        check("prio_busy9_c1", 64'(busy[9]), 64'd1);
        tick();
        check("prio_busy9_c2", 64'(busy[9]), 64'd1);
        tick();
        check("prio_busy9_c3", 64'(busy[9]), 64'd0);

        // Highest lane wins: lane1 var beats lane0 L=1.
        score_v = 2'b11; score_rd[0] = 5'd4; score_rd[1] = 5'd4;
        score_lat[0] = 3'd1; score_lat[1] = 3'd0;
        tick(); idle();
        repeat (3) tick();
        check("lane_prio_var4", 64'(busy[4]), 64'd1);
        clear_v[0] = 1'b1; clear_rd[0] = 5'd4;
        tick(); idle();

        // Clear coinciding with expiry, then a rescore that shortens r6.
        score_v[0] = 1'b1; score_rd[0] = 5'd8; score_lat[0] = 3'd1;
        tick(); idle();
        clear_v[1] = 1'b1; clear_rd[1] = 5'd8;
        tick(); idle();
        score_v[0] = 1'b1; score_rd[0] = 5'd6; score_lat[0] = 3'd5;
        tick(); idle();
        tick();
        score_v[0] = 1'b1; score_rd[0] = 5'd6; score_lat[0] = 3'd1;
        tick(); idle();
        check("rescore_busy6", 64'(busy[6]), 64'd1);
        tick();
        check("rescore_done6", 64'(busy[6]), 64'd0);

        // x0 is never scored.
        score_v[0] = 1'b1; score_rd[0] = 5'd0; score_lat[0] = 3'd0;
        rd[1] = 5'd0;
        #1 check("x0_rd_match", 64'(rd_match[1]), 64'd0);
        tick(); idle();
        check("x0_busy", 64'(busy), 64'h0);

        // Fill r1..r31 as var, then flush with a simultaneous score.
        for (int r = 1; r < RF; r += 2) begin
            score_v = (r + 1 < RF) ? 2'b11 : 2'b01;
            score_rd[0] = AW'(r); score_rd[1] = AW'(r + 1);
            score_lat = '0;
            tick();
        end
        idle();
        check("fill_busy", 64'(busy), 64'hffff_fffe);
        flush = 1'b1;
        score_v[0] = 1'b1; score_rd[0] = 5'd2; score_lat[0] = 3'd0;
        tick(); idle();
        check("flush_busy", 64'(busy), 64'h0);

        // Patterned traffic exercising all ports against the model.
        for (int n = 0; n < 40; n++) begin
            score_v = NI'(n % 4);
            score_rd[0] = AW'((n * 7) % 32);
            score_rd[1] = AW'((n * 11 + 3) % 32);
            score_lat[0] = LW'(n % 4);
            score_lat[1] = LW'((n * 5) % 8);
            clear_v = NC'((n * 3) % 4);
            clear_rd[0] = AW'((n * 13) % 32);
            clear_rd[1] = AW'((n * 7 + 1) % 32);
            flush = (n == 33);
            for (int i = 0; i < NI; i++) begin
                for (int k = 0; k < NR; k++) rs[i][k] = AW'((n * 3 + i * 5 + k * 9) % 32);
                rd[i] = AW'((n * 5 + i * 7) % 32);
            end
            tick();
        end
        idle();
        rs = '0; rd = '0;
        tick();

        // Asynchronous reset mid-countdown, between clock edges.
        score_v[0] = 1'b1; score_rd[0] = 5'd5; score_lat[0] = 3'd7;
        tick(); idle();
        tick();
        check("pre_reset_busy5", 64'(busy[5]), 64'd1);
        #2 rst_n = 1'b0;
        #1 check("async_reset_busy", 64'(busy), 64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bp_be_scoreboard_mi.md
# bp_be_scoreboard_mi

Multi-issue register scoreboard for the backend checker, tracking in-flight destination registers for `num_issue_p` instructions dispatched per cycle. Each entry holds either a fixed-latency countdown that self-clears or a variable-latency mark that waits for an explicit clear. It reports source (RAW) and destination (WAW) hazards per lane. Hazard reporting covers both in-flight state and older lanes of the same bundle. It sits between decode/issue and the dispatch stall logic.

## Interface
- `num_issue_p`, 2: lanes per bundle; lane 0 is oldest.
- `num_rs_p`, 3: source operands per lane.
- `num_clear_p`, 2: explicit clear ports (long-latency writeback).
- `reg_addr_width_p`, 5: register address width; `rf_els_lp = 2**reg_addr_width_p`.
- `lat_width_p`, 3: latency field width; max fixed latency `2**lat_width_p-1`.
- `clk_i`  in  1  clock, rising edge.
- `reset_n_i`  in  1  asynchronous active-low reset.
- `score_v_i`  in  `num_issue_p`  lane dispatches a register write.
- `score_rd_i`  in  `num_issue_p x reg_addr_width_p`  rd being scored.
- `score_lat_i`  in  `num_issue_p x lat_width_p`  cycles until result; 0 = variable latency.
- `clear_v_i`  in  `num_clear_p`  clear request.
- `clear_rd_i`  in  `num_clear_p x reg_addr_width_p`  register to clear.
- `flush_i`  in  1  squash all in-flight state.
- `rs_i`  in  `num_issue_p x num_rs_p x reg_addr_width_p`  sources of the candidate bundle.
- `rd_i`  in  `num_issue_p x reg_addr_width_p`  destinations of the candidate bundle.
- `rs_match_o`  out  `num_issue_p x num_rs_p`  RAW hazard per source.
- `rd_match_o`  out  `num_issue_p`  WAW hazard per lane.
- `busy_o`  out  `rf_els_lp`  per-register in-flight vector.

## Operation
- Each entry has a `busy` bit, a `var` bit, and a `cnt[lat_width_p]` counter. `busy_o[r] = busy[r]`.
- Register 0 is never scored. Scores and clears to r=0 are ignored, and x0 sources and destinations never match.
- Score, `score_lat_i = L > 0`:
  - Next state: `busy=1`, `var=0`, `cnt=L`.
  - Each later edge with `cnt>1` sets `cnt-1`.
  - An edge with `cnt==1` sets `busy=0`, `cnt=0`.
- Score, `L == 0`: `busy=1`, `var=1`, `cnt=0`. The entry holds until a clear or flush.
- Clear: sets `busy=0`, `var=0`, `cnt=0`. This applies to fixed entries too.
- Per-edge priority per entry, highest first:
  - `flush_i`: every entry goes to 0, and scores in the same cycle are dropped.
  - Score: if several lanes score the same rd, the highest lane index wins.
  - Clear.
  - Countdown.
- `rs_match_o[i][k]` is high when both of the following hold:
  - `rs_i[i][k] != 0`;
  - `busy[rs_i[i][k]]` is set, or some `j<i` has `score_v_i[j] && score_rd_i[j]==rs_i[i][k]`.
- `rd_match_o[i]` follows the same rule using `rd_i[i]`.
- The intra-bundle terms use `score_rd_i`/`score_v_i` of the same cycle. Issue logic drives `score_rd_i == rd_i` for lanes it commits.
- Outputs are combinational from the registered state plus current inputs. There is no clear-to-match bypass: a clear becomes visible one cycle later.

## Timing
- Reset: all entries are 0 while `reset_n_i` is low, independent of the clock. `busy_o=0`, and all matches are 0 except intra-bundle terms driven by inputs. Deassertion is synchronised externally.
- A fixed score with latency L in cycle t makes `busy` visible in cycles t+1 .. t+L. The entry is clear at t+L+1.
- A variable score in cycle t is visible from t+1 until the cycle after the clear edge.
- Clear and countdown-expiry on the same edge give a clear entry; there is no conflict.
- A score landing on an already-busy entry restarts it with the new L and var (rescore).
- `flush_i` in cycle t gives all-zero state at t+1.
- Counter never underflows: `cnt==0` with `busy==1` occurs only for var entries.

## Test plan
- Fixed latency: lane0 scores r5, L=3 at cycle 0. Expect `rs_match` for r5 high in cycles 1-3 and low in cycle 4, with `busy_o[5]` tracking the same.
- Variable latency: lane1 scores r7, L=0. Expect r7 busy for 20 idle cycles. `clear_v_i[1]` for r7 at cycle 20 gives low at 21.
- Intra-bundle: lane0 scores r3 and lane1 has `rs_i[1][0]=3`, `rd_i[1]=3`. Expect `rs_match_o[1][0]=1` and `rd_match_o[1]=1`, while lane0's own sources on r3 give 0 when the scoreboard is empty.
- Priority: in the same cycle, clear r9 and lane0 scores r9 with L=2. Expect r9 busy for 2 cycles. Lanes 0 and 1 both scoring r4 with L=1 and L=0 give a var entry.
- x0 and flush: a score to r0 never sets busy. Scoring r1-r31 var and then pulsing `flush_i` together with a lane0 score of r2 gives `busy_o==0` next cycle.
- Async reset: assert `reset_n_i` low mid-countdown without a clock edge. Expect `busy_o` to drop to 0 immediately.
